cnt_seq_ctrl: RTL and testbench
===============================

# cnt_seq_ctrl

Sequencing controller for the two-digit hex up/down counter datapath. Runs entirely on `clk100khz` and replaces the separate `clk1hz`/`clk10hz` count sources. It derives the auto-count rate with an internal prescaler and debounces the manual key. It issues single-cycle `step`/`clr` strobes with a direction qualifier to the counter, and enforces an optional stop-at-limit mode using the count value fed back from the datapath.

## Interface
Parameters:
- `DIV_AUTO`, default 100000: prescaler period in clocks for auto stepping (1 Hz at 100 kHz).
- `DEB_CYC`, default 1000: clocks of stable key level required to accept a change (10 ms).

Ports:
- `clk100khz` in, 1: sole clock; all logic is rising-edge.
- `rst` in, 1: synchronous, active-low reset.
- `en` in, 1: mode select; 1 = manual, 0 = auto.
- `din` in, 1: manual count key, active-low, raw and asynchronous.
- `add` in, 1: direction; 1 = up, 0 = down.
- `mode_stop` in, 1: 1 = halt at the limit, 0 = wrap freely.
- `lim_hi` in, 8: upper count limit, used when `mode_stop`=1.
- `cnt_val` in, 8: current count `{data2,data1}` from the datapath.
- `step` out, 1: one-cycle count strobe.
- `dir` out, 1: direction qualifying `step`; registered.
- `clr` out, 1: one-cycle datapath clear strobe.
- `state` out, 2: FSM state code.
- `at_limit` out, 1: registered limit flag.

## Operation
- Reset values, while `rst`=0 at an edge: `step`=0, `clr`=0, `dir`=1, `state`=IDLE, `at_limit`=0. Prescaler, debounce counter and synchronizer are 0. Debounced key level is 1 (released).
- FSM states:
  - IDLE (00): asserts `clr` for exactly one cycle, then moves to AUTO if `en`=0 or MANUAL if `en`=1.
  - AUTO (01): the prescaler counts 0..DIV_AUTO-1. On terminal count it wraps to 0 and issues a step request.
  - MANUAL (10): each debounced press (debounced level 1→0) issues one step request. Key release generates nothing.
  - HALT (11): no steps are issued.
- Mode change: a change of `en` while in AUTO or MANUAL switches to the other state on the next edge. The prescaler clears to 0 on entry to AUTO. A press pending at the switch is discarded.
- Limit condition: `lim` = (`add`=1 and `cnt_val`==`lim_hi`) or (`add`=0 and `cnt_val`==0). `at_limit` is `lim` registered every cycle.
- Step request handling:
  - If `mode_stop`=1 and `lim`=1, no `step` is issued and the FSM enters HALT.
  - Otherwise `step`=1 for one cycle, with `dir` equal to `add` sampled on the same edge.
- HALT exit: leaves HALT when `lim`=0 (direction reversed or count changed) or `mode_stop`=0. The exit goes to AUTO or MANUAL per the current `en`, with the prescaler cleared.
- `dir` updates from `add` every cycle, so it is valid on every `step` cycle.
- `mode_stop`=0: the datapath wraps 0xFF↔0x00 itself; the controller never halts.
- Debounce:
  - `din` passes through a 2-FF synchronizer.
  - The counter increments while the synchronized value differs from the debounced level and clears to 0 when they match.
  - When the count reaches DEB_CYC-1 and the values still differ, the debounced level takes the synchronized value and the counter clears.
  - Glitches shorter than DEB_CYC are rejected. The debouncer runs in all states.
- `step` and `clr` are never asserted in the same cycle. At most one `step` occurs per cycle.

## Timing
- Manual latency: `step` is high on edge N+DEB_CYC+2, where N is the first edge sampling `din`=0, provided `din` is held low throughout.
- Auto: the first `step` comes DIV_AUTO edges after entering AUTO. Subsequent steps are exactly every DIV_AUTO clocks.
- `clr` is high on the first edge after `rst` is released. The mode state is entered on the following edge.
- `at_limit` lags `cnt_val`/`add`/`lim_hi` by one clock. The halt decision uses the combinational `lim` on the request edge.
- Reset asserted mid-operation: on the next edge all outputs return to reset values, regardless of pending request, debounce or prescaler state.
- `cnt_val` is expected to reflect a `step` within one clock, as the datapath is clocked by the same clock.

## Test plan
Bench parameters: DIV_AUTO=4, DEB_CYC=3.
1. Reset with `en`=0, `add`=1, `mode_stop`=0 → `clr` pulse on edge 1 after release, `state`=01. `step` pulses on edges 6, 10, 14, with `dir`=1.
2. Manual mode: `en`=1, drive `din` low for 8 clocks → exactly one `step`, 5 edges after the first low sample. A 2-clock low glitch produces no `step`.
3. Stop-at-limit: `mode_stop`=1, `lim_hi`=0x05, `cnt_val`=0x05, `add`=1, auto tick → no `step`, `state`=11, `at_limit`=1. Set `add`=0 → exit to 01, and the next tick gives `step` with `dir`=0.
4. Down at zero: `cnt_val`=0x00, `add`=0, `mode_stop`=1 → HALT. Set `mode_stop`=0 → resume, next `step` has `dir`=0.
5. Mode switch: a press in progress in MANUAL, switch `en`=0 before it is accepted → no manual `step`. The first auto `step` comes 4 clocks after entering AUTO.
6. Reset mid-count: assert `rst`=0 one clock before the prescaler terminal → no `step`, all outputs at reset values. After release, a `clr` pulse and the auto sequence restart from 0.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cnt_seq_ctrl
// Sequencing controller for the two-digit hex up/down counter datapath.
// Generates single-cycle step/clr strobes with a direction qualifier. The
// auto-step rate comes from an internal prescaler, and the manual key is
// debounced. It can also stop at a count limit using the datapath feedback.
//
// Ports:
//   clk100khz  in   1  sole clock, rising edge
//   rst        in   1  synchronous reset, active low
//   en         in   1  1 = manual stepping, 0 = auto stepping
//   din        in   1  raw manual key, active low, asynchronous
//   add        in   1  direction, 1 = up, 0 = down
//   mode_stop  in   1  1 = halt at limit, 0 = wrap freely
//   lim_hi     in   8  upper count limit
//   cnt_val    in   8  current count fed back from the datapath
//   step       out  1  one-cycle count strobe
//   dir        out  1  direction qualifying step (registered add)
//   clr        out  1  one-cycle datapath clear strobe
//   state      out  2  FSM state code
//   at_limit   out  1  registered limit flag
// ----------------------------------------------------------------------------
module cnt_seq_ctrl #(
    parameter int unsigned DIV_AUTO = 100000,
    parameter int unsigned DEB_CYC  = 1000
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       add,
    input  logic       mode_stop,
    input  logic [7:0] lim_hi,
    input  logic [7:0] cnt_val,
    output logic       step,
    output logic       dir,
    output logic       clr,
    output logic [1:0] state,
    output logic       at_limit
);

    localparam int unsigned PW = (DIV_AUTO > 1) ? $clog2(DIV_AUTO) : 1;
    localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(DIV_AUTO - 1);
    localparam logic [DW-1:0] DEB_TC   = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_AUTO   = 2'b01,
        ST_MANUAL = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    state_t          r_state;
    logic            r_step;
    logic            r_clr;
    logic            r_dir;
    logic            r_at_limit;
    logic [PW-1:0]   r_presc;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic            r_deb_d;
    logic [DW-1:0]   r_deb_cnt;

    state_t          w_state_nx;
    logic            w_step_nx;
    logic            w_clr_nx;
    logic            w_req;
    logic            w_lim;
    logic            w_press;
    logic            w_presc_tc;
    logic            w_deb_diff;

    // Limit condition for the current direction
    assign w_lim = (add && (cnt_val == lim_hi)) || (!add && (cnt_val == 8'h00));

    assign w_presc_tc = (r_presc == PRESC_TC);
    assign w_deb_diff = (r_sync2 != r_deb);
    // Press = debounced level falling 1->0, seen one cycle after it settles
    assign w_press    = r_deb_d && !r_deb;

    // Next-state and strobe decode
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = 1'b0;
        w_clr_nx   = 1'b0;
        w_req      = 1'b0;
        case (r_state)
            // First cycle issues clr; second cycle enters the selected mode
            ST_IDLE: begin
                if (r_clr) begin
                    w_state_nx = en ? ST_MANUAL : ST_AUTO;
                end else begin
                    w_clr_nx = 1'b1;
                end
            end
            // A mode change wins over a coincident request
            ST_AUTO: begin
                if (en) begin
                    w_state_nx = ST_MANUAL;
                end else begin
                    w_req = w_presc_tc;
                end
            end
            ST_MANUAL: begin
                if (!en) begin
                    w_state_nx = ST_AUTO;
                end else begin
                    w_req = w_press;
                end
            end
            ST_HALT: begin
                if (!w_lim || !mode_stop) begin
                    w_state_nx = en ? ST_MANUAL : ST_AUTO;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_req) begin
            if (mode_stop && w_lim) begin
                w_state_nx = ST_HALT;
            end else begin
                w_step_nx = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk100khz) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_step     <= 1'b0;
            r_clr      <= 1'b0;
            r_dir      <= 1'b1;
            r_at_limit <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_step     <= w_step_nx;
            r_clr      <= w_clr_nx;
            r_dir      <= add;
            r_at_limit <= w_lim;
        end
    end

    // Prescaler runs only while staying in AUTO, so every entry starts at 0
    always_ff @(posedge clk100khz) begin
        if (!rst) begin
            r_presc <= '0;
        end else if ((r_state == ST_AUTO) && (w_state_nx == ST_AUTO)) begin
            r_presc <= w_presc_tc ? '0 : r_presc + PW'(1);
        end else begin
            r_presc <= '0;
        end
    end

    // Key synchronizer and debouncer
    always_ff @(posedge clk100khz) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b1;
            r_deb_d   <= 1'b1;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (w_deb_diff) begin
                if (r_deb_cnt == DEB_TC) begin
                    r_deb     <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DW'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign clr      = r_clr;
    assign state    = r_state;
    assign at_limit = r_at_limit;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cnt_seq_ctrl
// Self-checking bench for cnt_seq_ctrl with DIV_AUTO=4, DEB_CYC=3.
// Expected step/clr strobes (edge index and direction) are queued ahead of
// time and matched by a negedge monitor; limit flag is checked from a table.
// ----------------------------------------------------------------------------
module tb_cnt_seq_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned DEB = 3;

    logic       clk100khz = 1'b0;
    logic       rst;
    logic       en;
    logic       din;
    logic       add;
    logic       mode_stop;
    logic [7:0] lim_hi;
    logic [7:0] cnt_val;
    logic       step;
    logic       dir;
    logic       clr;
    logic [1:0] state;
    logic       at_limit;

    cnt_seq_ctrl #(
        .DIV_AUTO (DIV),
        .DEB_CYC  (DEB)
    ) dut (
        .clk100khz (clk100khz),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .add       (add),
        .mode_stop (mode_stop),
        .lim_hi    (lim_hi),
        .cnt_val   (cnt_val),
        .step      (step),
        .dir       (dir),
        .clr       (clr),
        .state     (state),
        .at_limit  (at_limit)
    );

    always #5 clk100khz = ~clk100khz;

    // Number of rising edges so far; at a negedge it names the latest edge
    int cyc = 0;
    always @(posedge clk100khz) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   at_edge;
        logic dir;
    } step_exp_t;

    typedef struct {
        logic       add;
        logic [7:0] cnt;
        logic [7:0] lim;
        logic       exp_lim;
    } lim_vec_t;

    step_exp_t step_q[$];
    int        clr_q[$];
    lim_vec_t  vecs[8];

    task automatic chk(input string name, input int act, input int want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, want);
        end
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) @(negedge clk100khz);
    endtask

    task automatic push_step(input int e, input logic d);
        step_exp_t s;
        s.at_edge = e;
        s.dir     = d;
        step_q.push_back(s);
    endtask

    // Scoreboard monitor for the strobes
    always @(negedge clk100khz) begin
        step_exp_t s;
        int        c;
        if (step) begin
            if (step_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_step at edge %0d: got step=1, expected 0", cyc);
            end else begin
                s = step_q.pop_front();
                chk("step_edge", cyc, s.at_edge);
                chk("step_dir", int'(dir), int'(s.dir));
            end
        end
        if (clr) begin
            if (clr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_clr at edge %0d: got clr=1, expected 0", cyc);
            end else begin
                c = clr_q.pop_front();
                chk("clr_edge", cyc, c);
            end
        end
        if (step && clr) begin
            n_tests++;
            n_fail++;
            $display("FAIL step_clr_overlap at edge %0d: got both 1, expected exclusive", cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_step"},     int'(step),     0);
        chk({tag, "_clr"},      int'(clr),      0);
        chk({tag, "_dir"},      int'(dir),      1);
        chk({tag, "_state"},    int'(state),    0);
        chk({tag, "_at_limit"}, int'(at_limit), 0);
    endtask

    initial begin
        int rel;
        int k0;
        int k1;
        int k;

        vecs[0] = '{1'b1, 8'h05, 8'h05, 1'b1};
        vecs[1] = '{1'b1, 8'h04, 8'h05, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h05, 1'b1};
        vecs[3] = '{1'b0, 8'h05, 8'h05, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'hFF, 1'b0};
        vecs[6] = '{1'b0, 8'h01, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b1};

        // Reset with add=0 and cnt=0 so dir/at_limit reset values are visible
        rst       = 1'b0;
        en        = 1'b0;
        din       = 1'b1;
        add       = 1'b0;
        mode_stop = 1'b0;
        lim_hi    = 8'hFF;
        cnt_val   = 8'h00;
        goto_edge(3);
        chk_reset_outputs("reset");

        // Auto sequence after release
        add     = 1'b1;
        cnt_val = 8'h10;
        rst     = 1'b1;
        rel     = cyc;
        clr_q.push_back(rel + 1);
        push_step(rel + 6,  1'b1);
        push_step(rel + 10, 1'b1);
        push_step(rel + 14, 1'b1);
        goto_edge(rel + 1);
        chk("idle_state", int'(state), 0);
        goto_edge(rel + 2);
        chk("auto_state", int'(state), 1);
        goto_edge(rel + 14);
        en = 1'b1;
        goto_edge(rel + 15);
        chk("manual_state", int'(state), 2);

        // Limit flag table, in MANUAL with the key released
        for (int i = 0; i < 8; i++) begin
            add     = vecs[i].add;
            cnt_val = vecs[i].cnt;
            lim_hi  = vecs[i].lim;
            @(negedge clk100khz);
            chk("at_limit_vec", int'(at_limit), int'(vecs[i].exp_lim));
            chk("dir_vec", int'(dir), int'(vecs[i].add));
        end

        // Manual press: one step 5 edges after first low sample, then a glitch
        add       = 1'b1;
        cnt_val   = 8'h10;
        lim_hi    = 8'hFF;
        mode_stop = 1'b0;
        @(negedge clk100khz);
        @(negedge clk100khz);
        k0  = cyc;
        din = 1'b0;
        push_step(k0 + 6, 1'b1);
        goto_edge(k0 + 8);
        din = 1'b1;
        goto_edge(k0 + 20);
        k1  = cyc;
        din = 1'b0;
        goto_edge(k1 + 2);
        din = 1'b1;
        goto_edge(k1 + 12);
        chk("manual_after_glitch", int'(state), 2);

        // Mode switch during a pending press
        k   = cyc;
        din = 1'b0;
        goto_edge(k + 2);
        en = 1'b0;
        push_step(k + 7, 1'b1);
        goto_edge(k + 3);
        chk("switch_state", int'(state), 1);

        // Stop at upper limit, then reverse direction
        goto_edge(k + 7);
        din       = 1'b1;
        mode_stop = 1'b1;
        lim_hi    = 8'h05;
        cnt_val   = 8'h05;
        goto_edge(k + 11);
        chk("halt_hi_state", int'(state), 3);
        chk("halt_hi_at_limit", int'(at_limit), 1);
        chk("halt_hi_step", int'(step), 0);
        goto_edge(k + 13);
        add = 1'b0;
        push_step(k + 18, 1'b0);
        goto_edge(k + 14);
        chk("exit_hi_state", int'(state), 1);

        // Stop at zero counting down, then release stop mode
        goto_edge(k + 18);
        cnt_val = 8'h00;
        goto_edge(k + 22);
        chk("halt_lo_state", int'(state), 3);
        goto_edge(k + 23);
        mode_stop = 1'b0;
        push_step(k + 28, 1'b0);
        goto_edge(k + 24);
        chk("exit_lo_state", int'(state), 1);

        // Reset one clock before the prescaler terminal
        goto_edge(k + 31);
        rst = 1'b0;
        goto_edge(k + 32);
        chk_reset_outputs("midreset");
        goto_edge(k + 33);
        rst = 1'b1;
        clr_q.push_back(k + 34);
        push_step(k + 39, 1'b0);
        goto_edge(k + 35);
        chk("restart_state", int'(state), 1);
        goto_edge(k + 40);
        en = 1'b1;
        goto_edge(k + 48);
        chk("final_state", int'(state), 2);
        chk("step_queue_left", step_q.size(), 0);
        chk("clr_queue_left", clr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
